// File: rtl/vga_fb_pkg.sv
// Shared constants and grant encoding for the VGA frame-buffer arbiter.
package vga_fb_pkg;
  localparam int DEFAULT_AW       = 19;
  localparam int DEFAULT_PW       = 24;
  localparam int DEFAULT_FB_DEPTH = 307200;
  localparam int READ_LAT         = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2,
    GNT_RD   = 2'd3
  } gnt_e;

  // Round-robin pointer values: which host port wins the next contention.
  localparam logic RR_WR = 1'b0;
  localparam logic RR_RD = 1'b1;
endpackage

// File: rtl/vga_fb_rr2.sv
// Two-port round-robin between host write and host read, overridden by the
// display request which always wins.
module vga_fb_rr2
  import vga_fb_pkg::*;
(
  input  logic       prio_req,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       rr_ptr,
  output logic [1:0] grant,
  output logic       rr_ptr_next
);

  always_comb begin
    grant       = GNT_NONE;
    rr_ptr_next = rr_ptr;
    if (prio_req) begin
      grant = GNT_DISP;
    end else if (wr_req && rd_req) begin
      // Only a genuine contention moves the pointer.
      grant       = (rr_ptr == RR_RD) ? GNT_RD : GNT_WR;
      rr_ptr_next = ~rr_ptr;
    end else if (wr_req) begin
      grant = GNT_WR;
    end else if (rd_req) begin
      grant = GNT_RD;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: display fetch has absolute priority, host write/read
// share leftover cycles. Fixed 3-cycle read latency through an external RAM.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int AW       = DEFAULT_AW,
  parameter int PW       = DEFAULT_PW,
  parameter int FB_DEPTH = DEFAULT_FB_DEPTH
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iDisp_Req,
  input  logic [AW-1:0] iDisp_Addr,
  output logic [7:0]    oDisp_R,
  output logic [7:0]    oDisp_G,
  output logic [7:0]    oDisp_B,
  input  logic          iWr_Valid,
  output logic          oWr_Ready,
  input  logic [AW-1:0] iWr_Addr,
  input  logic [PW-1:0] iWr_Data,
  input  logic          iRd_Valid,
  output logic          oRd_Ready,
  input  logic [AW-1:0] iRd_Addr,
  output logic [PW-1:0] oRd_Data,
  output logic          oRd_DValid,
  output logic          oMem_CE,
  output logic          oMem_WE,
  output logic [AW-1:0] oMem_Addr,
  output logic [PW-1:0] oMem_WData,
  input  logic [PW-1:0] iMem_RData,
  output logic          oErr,
  output logic [15:0]   oStall_Cnt
);

  localparam logic [AW-1:0] DEPTH_A = AW'(FB_DEPTH);

  logic       rr_ptr, rr_ptr_next;
  logic [1:0] grant;
  logic [1:0] tag1, tag2;
  logic       zero1, zero2;
  logic       wr_oor, rd_oor, host_pend, host_gnt;

  vga_fb_rr2 u_rr2 (
    .prio_req    (iDisp_Req),
    .wr_req      (iWr_Valid),
    .rd_req      (iRd_Valid),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .rr_ptr_next (rr_ptr_next)
  );

  assign wr_oor    = (iWr_Addr >= DEPTH_A);
  assign rd_oor    = (iRd_Addr >= DEPTH_A);
  assign host_pend = iWr_Valid | iRd_Valid;
  assign host_gnt  = (grant == GNT_WR) || (grant == GNT_RD);

  // Readies are forced low while reset is held so nothing is accepted then.
  assign oWr_Ready = iRST_N & iWr_Valid & (grant == GNT_WR);
  assign oRd_Ready = iRST_N & iRd_Valid & (grant == GNT_RD);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rr_ptr     <= RR_WR;
      tag1       <= GNT_NONE;
      tag2       <= GNT_NONE;
      zero1      <= 1'b0;
      zero2      <= 1'b0;
      oMem_CE    <= 1'b0;
      oMem_WE    <= 1'b0;
      oMem_Addr  <= '0;
      oMem_WData <= '0;
      oDisp_R    <= '0;
      oDisp_G    <= '0;
      oDisp_B    <= '0;
      oRd_Data   <= '0;
      oRd_DValid <= 1'b0;
      oErr       <= 1'b0;
      oStall_Cnt <= '0;
    end else begin
      rr_ptr  <= rr_ptr_next;
      tag1    <= grant;
      zero1   <= 1'b0;
      oMem_CE <= 1'b0;
      oMem_WE <= 1'b0;
      case (grant)
        GNT_DISP: begin
          oMem_CE   <= 1'b1;
          oMem_Addr <= iDisp_Addr;
        end
        GNT_WR: begin
          if (wr_oor) begin
            oErr <= 1'b1;
          end else begin
            oMem_CE    <= 1'b1;
            oMem_WE    <= 1'b1;
            oMem_Addr  <= iWr_Addr;
            oMem_WData <= iWr_Data;
          end
        end
        GNT_RD: begin
          // Out-of-range reads skip the RAM and return zero at stage 3.
          if (rd_oor) begin
            oErr  <= 1'b1;
            zero1 <= 1'b1;
          end else begin
            oMem_CE   <= 1'b1;
            oMem_Addr <= iRd_Addr;
          end
        end
        default: ;
      endcase

      tag2  <= tag1;
      zero2 <= zero1;

      if (tag2 == GNT_DISP) begin
        oDisp_R <= iMem_RData[PW-1 -: 8];
        oDisp_G <= iMem_RData[PW-9 -: 8];
        oDisp_B <= iMem_RData[PW-17 -: 8];
      end else begin
        oDisp_R <= '0;
        oDisp_G <= '0;
        oDisp_B <= '0;
      end

      oRd_DValid <= (tag2 == GNT_RD);
      if (tag2 == GNT_RD) oRd_Data <= zero2 ? '0 : iMem_RData;

      if (host_pend && !host_gnt && (oStall_Cnt != 16'hFFFF))
        oStall_Cnt <= oStall_Cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised bench for vga_fb_arbiter: a behavioural RAM, a per-slot reference
// model of grants/latency/memory contents, and an expected-read queue.
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam int AW    = DEFAULT_AW;
  localparam int PW    = DEFAULT_PW;
  localparam int DEPTH = DEFAULT_FB_DEPTH;

  // ---------------- clock / reset ----------------
  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  always #20 iCLK = ~iCLK;

  logic          iDisp_Req = 1'b0;
  logic [AW-1:0] iDisp_Addr = '0;
  logic [7:0]    oDisp_R, oDisp_G, oDisp_B;
  logic          iWr_Valid = 1'b0;
  logic          oWr_Ready;
  logic [AW-1:0] iWr_Addr = '0;
  logic [PW-1:0] iWr_Data = '0;
  logic          iRd_Valid = 1'b0;
  logic          oRd_Ready;
  logic [AW-1:0] iRd_Addr = '0;
  logic [PW-1:0] oRd_Data;
  logic          oRd_DValid;
  logic          oMem_CE, oMem_WE;
  logic [AW-1:0] oMem_Addr;
  logic [PW-1:0] oMem_WData;
  logic [PW-1:0] iMem_RData = '0;
  logic          oErr;
  logic [15:0]   oStall_Cnt;

  vga_fb_arbiter dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iDisp_Req(iDisp_Req), .iDisp_Addr(iDisp_Addr),
    .oDisp_R(oDisp_R), .oDisp_G(oDisp_G), .oDisp_B(oDisp_B),
    .iWr_Valid(iWr_Valid), .oWr_Ready(oWr_Ready), .iWr_Addr(iWr_Addr), .iWr_Data(iWr_Data),
    .iRd_Valid(iRd_Valid), .oRd_Ready(oRd_Ready), .iRd_Addr(iRd_Addr),
    .oRd_Data(oRd_Data), .oRd_DValid(oRd_DValid),
    .oMem_CE(oMem_CE), .oMem_WE(oMem_WE), .oMem_Addr(oMem_Addr), .oMem_WData(oMem_WData),
    .iMem_RData(iMem_RData), .oErr(oErr), .oStall_Cnt(oStall_Cnt)
  );

  // Single-port synchronous RAM, contents default to zero.
  logic [PW-1:0] ram [logic [AW-1:0]];
  always @(posedge iCLK) begin
    if (oMem_CE) begin
      if (oMem_WE) ram[oMem_Addr] = oMem_WData;
      else iMem_RData <= ram.exists(oMem_Addr) ? ram[oMem_Addr] : '0;
    end
  end

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] ref_mem [logic [AW-1:0]];
  logic [PW-1:0] exp_q[$];
  logic          exp_dv   [0:7];
  logic [PW-1:0] exp_disp [0:7];
  int            slot;
  logic          pref_rd;
  logic          exp_err;
  int            exp_stall;
  logic [PW-1:0] last_rd;
  logic          exp_ce, exp_we;
  logic [AW-1:0] exp_addr;
  logic [PW-1:0] exp_wdata;
  logic          wr_acc, rd_acc;

  logic          drv_disp, drv_wr, drv_rd;
  logic [AW-1:0] drv_disp_addr, drv_wr_addr, drv_rd_addr;
  logic [PW-1:0] drv_wr_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (slot %0d)", tag, got, exp, slot);
    end
  endtask

  function automatic logic [PW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      exp_dv[i]   = 1'b0;
      exp_disp[i] = '0;
    end
    exp_q.delete();
    slot = 0; pref_rd = 1'b0; exp_err = 1'b0; exp_stall = 0; last_rd = '0;
    exp_ce = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    wr_acc = 1'b0; rd_acc = 1'b0;
  endtask

  // ---------------- driver ----------------
  // One pixel-clock slot: check outputs produced so far, apply drv_* for the
  // next rising edge, then predict what that edge and the pipeline will do.
  task automatic step();
    int i, j;
    logic host_ok, g_wr, g_rd;
    @(negedge iCLK);
    i = slot % 8;
    check("disp_pix", 32'({oDisp_R, oDisp_G, oDisp_B}), 32'(exp_disp[i]));
    check("rd_dvalid", 32'(oRd_DValid), 32'(exp_dv[i]));
    if (exp_dv[i]) begin
      if (exp_q.size() == 0) check("rd_queue", 32'(oRd_DValid), 32'(0));
      else last_rd = exp_q.pop_front();
    end
    check("rd_data", 32'(oRd_Data), 32'(last_rd));
    check("mem_ce", 32'(oMem_CE), 32'(exp_ce));
    check("mem_we", 32'(oMem_WE), 32'(exp_we));
    check("mem_addr", 32'(oMem_Addr), 32'(exp_addr));
    if (exp_we) check("mem_wdata", 32'(oMem_WData), 32'(exp_wdata));
    check("err", 32'(oErr), 32'(exp_err));
    check("stall_cnt", 32'(oStall_Cnt), exp_stall);
    exp_dv[i] = 1'b0;
    exp_disp[i] = '0;

    iDisp_Req = drv_disp; iDisp_Addr = drv_disp_addr;
    iWr_Valid = drv_wr;   iWr_Addr = drv_wr_addr; iWr_Data = drv_wr_data;
    iRd_Valid = drv_rd;   iRd_Addr = drv_rd_addr;
    #1;

    host_ok = !drv_disp;
    g_wr = host_ok && drv_wr && (!drv_rd || !pref_rd);
    g_rd = host_ok && drv_rd && (!drv_wr || pref_rd);
    if (host_ok && drv_wr && drv_rd) pref_rd = !pref_rd;
    check("wr_ready", 32'(oWr_Ready), 32'(g_wr));
    check("rd_ready", 32'(oRd_Ready), 32'(g_rd));
    wr_acc = g_wr;
    rd_acc = g_rd;

    j = (slot + READ_LAT) % 8;
    exp_ce = 1'b0;
    exp_we = 1'b0;
    if (drv_disp) begin
      exp_ce = 1'b1; exp_addr = drv_disp_addr;
      exp_disp[j] = ref_read(drv_disp_addr);
    end else if (g_wr) begin
      if (in_range(drv_wr_addr)) begin
        exp_ce = 1'b1; exp_we = 1'b1; exp_addr = drv_wr_addr; exp_wdata = drv_wr_data;
        ref_mem[drv_wr_addr] = drv_wr_data;
      end else exp_err = 1'b1;
    end else if (g_rd) begin
      exp_dv[j] = 1'b1;
      if (in_range(drv_rd_addr)) begin
        exp_ce = 1'b1; exp_addr = drv_rd_addr;
        exp_q.push_back(ref_read(drv_rd_addr));
      end else begin
        exp_err = 1'b1;
        exp_q.push_back('0);
      end
    end
    if ((drv_wr || drv_rd) && !g_wr && !g_rd && exp_stall < 65535) exp_stall++;
    slot++;
  endtask

  task automatic do_reset(input int cycles);
    drv_disp = 1'b0; drv_wr = 1'b0; drv_rd = 1'b0;
    iRST_N = 1'b0;
    // Host valids are held high during reset to show nothing is accepted.
    iDisp_Req = 1'b0; iWr_Valid = 1'b1; iRd_Valid = 1'b1;
    repeat (cycles) begin
      @(negedge iCLK);
      check("rst_outputs_zero", 32'(|{oDisp_R, oDisp_G, oDisp_B, oRd_Data, oRd_DValid, oWr_Ready,
             oRd_Ready, oMem_CE, oMem_WE, oMem_Addr, oMem_WData, oErr, oStall_Cnt}), 32'(0));
    end
    model_reset();
    iWr_Valid = 1'b0; iRd_Valid = 1'b0;
    iRST_N = 1'b1;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [PW-1:0] d);
    int budget = 40;
    drv_wr = 1'b1; drv_wr_addr = a; drv_wr_data = d;
    do begin step(); budget--; end while (!wr_acc && budget > 0);
    if (!wr_acc) check("wr_accept", 32'(oWr_Ready), 32'(1));
    drv_wr = 1'b0;
  endtask

  task automatic host_rd(input logic [AW-1:0] a);
    int budget = 40;
    drv_rd = 1'b1; drv_rd_addr = a;
    do begin step(); budget--; end while (!rd_acc && budget > 0);
    if (!rd_acc) check("rd_accept", 32'(oRd_Ready), 32'(1));
    drv_rd = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 15))
      0:       return AW'(DEPTH);
      1:       return '1;
      default: return AW'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int run_left;
    drv_disp_addr = '0; drv_wr_addr = '0; drv_rd_addr = '0; drv_wr_data = '0;
    model_reset();
    do_reset(3);
    repeat (4) step();

    // Write then read back the same word.
    host_wr(AW'(5), 24'h123456);
    host_rd(AW'(5));
    repeat (4) step();
    check("rd_back_5", 32'(last_rd), 32'(24'h123456));

    // Display priority starves a pending write for 10 cycles.
    drv_disp = 1'b1; drv_disp_addr = AW'(5);
    drv_wr = 1'b1; drv_wr_addr = AW'(7); drv_wr_data = 24'hA5A5A5;
    repeat (10) begin
      step();
      check("wr_blocked", 32'(oWr_Ready), 32'(0));
    end
    drv_disp = 1'b0;
    step();
    check("stall_10", 32'(oStall_Cnt), 32'(10));
    check("wr_after_disp", 32'(oWr_Ready), 32'(1));
    drv_wr = 1'b0;
    repeat (4) step();

    // Contending host ports alternate starting with the write port.
    do_reset(2);
    drv_wr = 1'b1; drv_wr_addr = AW'(20); drv_wr_data = 24'h0badf0;
    drv_rd = 1'b1; drv_rd_addr = AW'(20);
    for (int k = 0; k < 4; k++) begin
      step();
      check("alt_wr", 32'(oWr_Ready), 32'(k % 2 == 0));
      check("alt_rd", 32'(oRd_Ready), 32'(k % 2 == 1));
    end
    drv_wr = 1'b0; drv_rd = 1'b0;
    repeat (4) step();

    // Out-of-range write: handshaken, RAM untouched, sticky error.
    host_wr(AW'(DEPTH), 24'hFFFFFF);
    step();
    check("oor_ce", 32'(oMem_CE), 32'(0));
    check("oor_err", 32'(oErr), 32'(1));
    host_rd(AW'(DEPTH + 3));
    repeat (6) step();
    check("err_sticky", 32'(oErr), 32'(1));
    do_reset(2);
    step();
    check("err_cleared", 32'(oErr), 32'(0));

    // Reset one cycle after a read is accepted discards it.
    host_wr(AW'(9), 24'h99AA55);
    host_rd(AW'(9));
    step();
    do_reset(3);
    repeat (5) begin
      step();
      check("no_dvalid_after_rst", 32'(oRd_DValid), 32'(0));
    end

    // Randomised traffic: display bursts with pending host requests.
    run_left = 0;
    for (int n = 0; n < 2500; n++) begin
      if (!drv_wr && $urandom_range(0, 2) == 0) begin
        drv_wr = 1'b1; drv_wr_addr = rand_addr(); drv_wr_data = PW'($urandom());
      end
      if (!drv_rd && $urandom_range(0, 2) == 0) begin
        drv_rd = 1'b1; drv_rd_addr = rand_addr();
      end
      if (run_left == 0) begin
        drv_disp = ($urandom_range(0, 9) < 6);
        run_left = $urandom_range(1, 12);
      end
      run_left--;
      drv_disp_addr = AW'($urandom_range(0, 63));
      step();
      if (wr_acc) drv_wr = 1'b0;
      if (rd_acc) drv_rd = 1'b0;
    end
    drv_disp = 1'b0; drv_wr = 1'b0; drv_rd = 1'b0;
    repeat (6) step();
    check("rd_queue_drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
